// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdm_pkg
// Purpose  : Shared constants and state encoding for the 8-slot TDM nibble
//            link. Used by both the receive-side demultiplexer and the
//            transmit-side sequencer.
// Contents : NUM_SLOTS, SLOT_W, TDM_WIDTH, tdm_state_t
// Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;
    localparam int TDM_WIDTH = 4;

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
// Module   : tdm_slot_counter
// Purpose  : Slot index tracker for the TDM demultiplexer. Holds the slot
//            expected for the next valid word.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            i_load1        - sync accepted; slot 0 just written, go to 1
//            i_inc          - valid word accepted; advance with wrap 7->0
//            o_slot         - current slot index
//            o_terminal     - current slot is the last slot of the frame
// Revision : 1.0 - initial release
// ============================================================================
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load1,
    input  logic              i_inc,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_terminal
);

    logic [SLOT_W-1:0] r_slot;

    // Load-to-1 wins over increment: a resync always restarts the frame.
    // Wrap 7->0 falls out of the natural 3-bit overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
        end else if (i_load1) begin
            r_slot <= SLOT_W'(1);
        end else if (i_inc) begin
            r_slot <= r_slot + SLOT_W'(1);
        end
    end

    assign o_slot     = r_slot;
    assign o_terminal = (r_slot == SLOT_W'(NUM_SLOTS - 1));

endmodule
`default_nettype wire

// File: rtl/tdm_demux_1to8.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_1to8
// Purpose  : Receive-side 1-to-8 TDM demultiplexer. Locks to SYNC-marked
//            slot 0, collects seven words in shadow registers and presents
//            the complete frame on O0..O7 with a one-cycle FRAME_VALID.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            D, D_VALID     - incoming word and its qualifier
//            SYNC           - current word is slot 0 (only when D_VALID)
//            O0..O7         - registered channel outputs
//            FRAME_VALID    - pulse, O0..O7 just updated
//            SLOT           - slot expected for the next valid word
//            LOCKED         - framing acquired
//            SYNC_ERR       - pulse, SYNC arrived at a nonzero slot
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux_1to8
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    input  logic             SYNC,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic [WIDTH-1:0] O4,
    output logic [WIDTH-1:0] O5,
    output logic [WIDTH-1:0] O6,
    output logic [WIDTH-1:0] O7,
    output logic             FRAME_VALID,
    output logic [2:0]       SLOT,
    output logic             LOCKED,
    output logic             SYNC_ERR
);

    tdm_state_t        r_state;
    tdm_state_t        w_state_next;

    logic [SLOT_W-1:0] w_slot;
    logic              w_terminal;
    logic              w_load1;
    logic              w_inc;
    logic              w_wr_shadow;
    logic [SLOT_W-1:0] w_wr_idx;
    logic              w_frame_done;
    logic              w_sync_err;

    // Slot 7 never needs a shadow: its word goes straight to O7.
    logic [WIDTH-1:0]  r_shadow [NUM_SLOTS-1];
    logic [WIDTH-1:0]  r_out    [NUM_SLOTS];
    logic              r_frame_valid;
    logic              r_sync_err;

    tdm_slot_counter u_slot_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load1    (w_load1),
        .i_inc      (w_inc),
        .o_slot     (w_slot),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load1      = 1'b0;
        w_inc        = 1'b0;
        w_wr_shadow  = 1'b0;
        w_frame_done = 1'b0;
        w_sync_err   = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (D_VALID && SYNC) begin
                    w_load1      = 1'b1;
                    w_wr_shadow  = 1'b1;
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (D_VALID) begin
                    if (SYNC && (w_slot != '0)) begin
                        // Misplaced SYNC: drop the partial frame and restart
                        // with this word as slot 0.
                        w_sync_err  = 1'b1;
                        w_load1     = 1'b1;
                        w_wr_shadow = 1'b1;
                    end else begin
                        w_inc = 1'b1;
                        if (w_terminal) begin
                            w_frame_done = 1'b1;
                        end else begin
                            w_wr_shadow = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_next = ST_HUNT;
            end
        endcase
    end

    assign w_wr_idx = w_load1 ? '0 : w_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                r_shadow[i] <= '0;
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_out[i] <= '0;
            end
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= w_frame_done;
            r_sync_err    <= w_sync_err;
            if (w_wr_shadow) begin
                r_shadow[w_wr_idx] <= D;
            end
            if (w_frame_done) begin
                for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                    r_out[i] <= r_shadow[i];
                end
                r_out[NUM_SLOTS-1] <= D;
            end
        end
    end

    assign O0          = r_out[0];
    assign O1          = r_out[1];
    assign O2          = r_out[2];
    assign O3          = r_out[3];
    assign O4          = r_out[4];
    assign O5          = r_out[5];
    assign O6          = r_out[6];
    assign O7          = r_out[7];
    assign FRAME_VALID = r_frame_valid;
    assign SYNC_ERR    = r_sync_err;
    assign SLOT        = w_slot;
    assign LOCKED      = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_1to8.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux_1to8
// Purpose  : Self-checking bench for tdm_demux_1to8. Expected frames are
//            queued when the slot-7 word is driven and popped when
//            FRAME_VALID is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_1to8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D;
    logic       D_VALID;
    logic       SYNC;
    logic [3:0] O0, O1, O2, O3, O4, O5, O6, O7;
    logic       FRAME_VALID;
    logic [2:0] SLOT;
    logic       LOCKED;
    logic       SYNC_ERR;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int fv_cnt = 0;
    int se_cnt = 0;

    logic [31:0] exp_q [$];
    logic [31:0] exp_frame;
    logic [31:0] frame;

    assign frame = {O0, O1, O2, O3, O4, O5, O6, O7};

    tdm_demux_1to8 #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .D           (D),
        .D_VALID     (D_VALID),
        .SYNC        (SYNC),
        .O0          (O0),
        .O1          (O1),
        .O2          (O2),
        .O3          (O3),
        .O4          (O4),
        .O5          (O5),
        .O6          (O6),
        .O7          (O7),
        .FRAME_VALID (FRAME_VALID),
        .SLOT        (SLOT),
        .LOCKED      (LOCKED),
        .SYNC_ERR    (SYNC_ERR)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (FRAME_VALID) fv_cnt <= fv_cnt + 1;
        if (SYNC_ERR)    se_cnt <= se_cnt + 1;
    end

    task automatic send(input logic [3:0] d, input logic s);
        D       = d;
        D_VALID = 1'b1;
        SYNC    = s;
        @(posedge clk);
        #1;
        D_VALID = 1'b0;
        SYNC    = 1'b0;
        D       = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; D = 4'h0; D_VALID = 1'b0; SYNC = 1'b0;
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            checks++;
            if ({frame, FRAME_VALID, SYNC_ERR, LOCKED, SLOT} !== 38'h0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: got frame=%h fv=%b se=%b lk=%b slot=%0d, want all 0",
                         i, frame, FRAME_VALID, SYNC_ERR, LOCKED, SLOT);
            end
        end
    endtask

    task automatic test_basic;
        int c0;
        send(4'h5, 1'b0);
        send(4'h6, 1'b0);
        checks++;
        if (LOCKED !== 1'b0 || SLOT !== 3'd0) begin
            errors++;
            $display("FAIL hunt_ignore: got locked=%b slot=%0d, want 0/0", LOCKED, SLOT);
        end
        send(4'h1, 1'b1);
        c0 = cyc;
        checks++;
        if (LOCKED !== 1'b1 || SLOT !== 3'd1) begin
            errors++;
            $display("FAIL lock_acquire: got locked=%b slot=%0d, want 1/1", LOCKED, SLOT);
        end
        for (int k = 2; k <= 8; k++) begin
            if (k == 8) exp_q.push_back(32'h12345678);
            send(4'(k), 1'b0);
            checks++;
            if (FRAME_VALID !== 1'(k == 8)) begin
                errors++;
                $display("FAIL basic_fv word%0d: got %b want %b", k, FRAME_VALID, (k == 8));
            end
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL basic_frame: scoreboard empty");
        end else begin
            exp_frame = exp_q.pop_front();
            if (frame !== exp_frame) begin
                errors++;
                $display("FAIL basic_frame: got %h want %h", frame, exp_frame);
            end
        end
        checks++;
        if (cyc - c0 != 7) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 7", cyc - c0);
        end
        idle(1);
        checks++;
        if (FRAME_VALID !== 1'b0) begin
            errors++;
            $display("FAIL basic_fv_drop: got %b want 0", FRAME_VALID);
        end
    endtask

    task automatic test_gap;
        int c0;
        int fv0;
        fv0 = fv_cnt;
        send(4'h1, 1'b1);
        c0 = cyc;
        for (int k = 2; k <= 4; k++) send(4'(k), 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            checks++;
            if (SLOT !== 3'd4 || FRAME_VALID !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold%0d: got slot=%0d fv=%b want 4/0", i, SLOT, FRAME_VALID);
            end
        end
        for (int k = 5; k <= 8; k++) begin
            if (k == 8) exp_q.push_back(32'h12345678);
            send(4'(k), 1'b0);
        end
        checks++;
        if (FRAME_VALID !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL gap_fv: got fv=%b q=%0d want 1", FRAME_VALID, exp_q.size());
        end else begin
            exp_frame = exp_q.pop_front();
            if (frame !== exp_frame) begin
                errors++;
                $display("FAIL gap_frame: got %h want %h", frame, exp_frame);
            end
        end
        checks++;
        if (cyc - c0 != 10) begin
            errors++;
            $display("FAIL gap_latency: got %0d want 10", cyc - c0);
        end
        idle(3);
        checks++;
        if (fv_cnt - fv0 != 1) begin
            errors++;
            $display("FAIL gap_pulses: got %0d want 1", fv_cnt - fv0);
        end
    endtask

    task automatic test_sync_err;
        int se0;
        se0 = se_cnt;
        send(4'hA, 1'b1);
        send(4'hB, 1'b0);
        send(4'hC, 1'b0);
        send(4'hF, 1'b1);
        checks++;
        if (SYNC_ERR !== 1'b1 || SLOT !== 3'd1 || FRAME_VALID !== 1'b0 || frame !== 32'h12345678) begin
            errors++;
            $display("FAIL serr_resync: got se=%b slot=%0d fv=%b frame=%h want 1/1/0/12345678",
                     SYNC_ERR, SLOT, FRAME_VALID, frame);
        end
        for (int k = 0; k <= 6; k++) begin
            if (k == 6) exp_q.push_back(32'hF0123456);
            send(4'(k), 1'b0);
            checks++;
            if (k < 6) begin
                if (frame !== 32'h12345678 || SYNC_ERR !== 1'b0 || FRAME_VALID !== 1'b0) begin
                    errors++;
                    $display("FAIL serr_hold word%0d: got frame=%h se=%b fv=%b want 12345678/0/0",
                             k, frame, SYNC_ERR, FRAME_VALID);
                end
            end else if (FRAME_VALID !== 1'b1 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL serr_fv: got fv=%b q=%0d want 1", FRAME_VALID, exp_q.size());
            end else begin
                exp_frame = exp_q.pop_front();
                if (frame !== exp_frame) begin
                    errors++;
                    $display("FAIL serr_frame: got %h want %h", frame, exp_frame);
                end
            end
        end
        idle(1);
        checks++;
        if (se_cnt - se0 != 1) begin
            errors++;
            $display("FAIL serr_pulses: got %0d want 1", se_cnt - se0);
        end
    endtask

    task automatic test_sync_slot7;
        send(4'h1, 1'b1);
        for (int k = 2; k <= 7; k++) send(4'(k), 1'b0);
        send(4'h9, 1'b1);
        checks++;
        if (SYNC_ERR !== 1'b1 || FRAME_VALID !== 1'b0 || SLOT !== 3'd1 ||
            LOCKED !== 1'b1 || frame !== 32'hF0123456) begin
            errors++;
            $display("FAIL slot7_sync: got se=%b fv=%b slot=%0d lk=%b frame=%h want 1/0/1/1/f0123456",
                     SYNC_ERR, FRAME_VALID, SLOT, LOCKED, frame);
        end
        idle(1);
        checks++;
        if (SYNC_ERR !== 1'b0) begin
            errors++;
            $display("FAIL slot7_se_drop: got %b want 0", SYNC_ERR);
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 2; k <= 4; k++) send(4'(k), 1'b0);
        checks++;
        if (SLOT !== 3'd4) begin
            errors++;
            $display("FAIL rstmid_pre: got slot=%0d want 4", SLOT);
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++;
        if ({frame, FRAME_VALID, SYNC_ERR, LOCKED, SLOT} !== 38'h0) begin
            errors++;
            $display("FAIL rstmid_clear: got frame=%h fv=%b se=%b lk=%b slot=%0d want all 0",
                     frame, FRAME_VALID, SYNC_ERR, LOCKED, SLOT);
        end
        send(4'h3, 1'b0);
        checks++;
        if (LOCKED !== 1'b0 || SLOT !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_hunt: got lk=%b slot=%0d want 0/0", LOCKED, SLOT);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] acc;
        logic [3:0]  w;
        int          fv_at [2];
        for (int f = 0; f < 2; f++) begin
            acc = 32'h0;
            for (int k = 0; k < 8; k++) begin
                w   = (f == 0) ? 4'(k + 1) : 4'(8 - k);
                acc = {acc[27:0], w};
                if (k == 7) exp_q.push_back(acc);
                send(w, 1'(k == 0));
                if (k == 7) begin
                    fv_at[f] = cyc;
                    checks++;
                    if (FRAME_VALID !== 1'b1 || exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL b2b_fv%0d: got fv=%b q=%0d want 1", f, FRAME_VALID, exp_q.size());
                    end else begin
                        exp_frame = exp_q.pop_front();
                        if (frame !== exp_frame) begin
                            errors++;
                            $display("FAIL b2b_frame%0d: got %h want %h", f, frame, exp_frame);
                        end
                    end
                end
            end
        end
        checks++;
        if (fv_at[1] - fv_at[0] != 8) begin
            errors++;
            $display("FAIL b2b_period: got %0d want 8", fv_at[1] - fv_at[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_sync_err();
        test_sync_slot7();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
